// File: rtl/linebuf_dbl_ctl_if.sv
// Signal bundle between the CGA->VGA line buffer controller and its
// surroundings: CGA timing inputs, line-buffer RAM control, VGA timing outputs.
// The controller takes the slave modport; the driving side takes master.
interface linebuf_dbl_ctl_if #(
    parameter int ADDR_W = 9
);
    logic              cga_pix_ce;
    logic              cga_hsync_i;
    logic              cga_vsync_i;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              vga_hsync_o;
    logic              vga_vsync_o;
    logic              blank_o;
    logic              overrun;
    logic              scan_dim;

    modport slave (
        input  cga_pix_ce, cga_hsync_i, cga_vsync_i,
        output wr_en, wr_bank, wr_addr, rd_bank, rd_addr, rd_valid,
               vga_hsync_o, vga_vsync_o, blank_o, overrun, scan_dim
    );

    modport master (
        output cga_pix_ce, cga_hsync_i, cga_vsync_i,
        input  wr_en, wr_bank, wr_addr, rd_bank, rd_addr, rd_valid,
               vga_hsync_o, vga_vsync_o, blank_o, overrun, scan_dim
    );
endinterface

// File: rtl/linebuf_dbl_ctl.sv
// Ping-pong line buffer sequencer for the CGA->VGA scan converter.
// Each CGA line is written into one bank while the other bank is replayed
// twice at VGA rate with 2x horizontal pixel doubling.
// Optional macro LINEBUF_SCANLINE_EN: flags second-pass pixels on scan_dim.
//
// state | meaning
// ------+-------------------------------------------------------------
// PASS0 | first replay of the buffered line
// PASS1 | second replay of the buffered line
// WAIT  | both replays done, output blanked until the next line start
module linebuf_dbl_ctl #(
    parameter int CGA_W    = 256,
    parameter int ADDR_W   = 9,
    parameter int H_TOTAL  = 800,
    parameter int H_ACTIVE = 640,
    parameter int HS_START = 656,
    parameter int HS_END   = 752
) (
    input logic             clk25m,
    input logic             reset,
    linebuf_dbl_ctl_if.slave lb
);
    localparam int HC_W = $clog2(H_TOTAL);

    localparam logic [HC_W-1:0]   HC_LAST = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W:0]     RD_END  = (HC_W+1)'(2 * CGA_W);
    localparam logic [HC_W:0]     ACT_END = (HC_W+1)'(H_ACTIVE);
    localparam logic [HC_W:0]     HS_S    = (HC_W+1)'(HS_START);
    localparam logic [HC_W:0]     HS_E    = (HC_W+1)'(HS_END);
    localparam logic [ADDR_W:0]   W_LAST  = (ADDR_W+1)'(CGA_W - 1);

    generate
        if (2 * CGA_W > H_ACTIVE) begin : g_bad_active
            $error("linebuf_dbl_ctl: 2*CGA_W must not exceed H_ACTIVE");
        end
        if ((1 << ADDR_W) < CGA_W) begin : g_bad_addr
            $error("linebuf_dbl_ctl: ADDR_W too small for CGA_W");
        end
        if (HC_W < ADDR_W + 1) begin : g_bad_hc
            $error("linebuf_dbl_ctl: hcount too narrow for the read address");
        end
    endgenerate

    typedef enum logic [1:0] {PASS0, PASS1, WAIT} state_t;

    state_t            state_q, state_d;
    logic [HC_W-1:0]   hcount_q, hcount_d;
    logic [HC_W:0]     hc_ext;

    logic              hs_q, hs_prev_q;
    logic              vs1_q, vs2_q;
    logic              ls;

    logic [ADDR_W:0]   wptr_q;
    logic              armed_q;
    logic              wr_en_q, wr_bank_q, rd_bank_q;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic              rd_valid_q, blank_q, hsync_q, overrun_q;

    assign ls     = hs_prev_q & ~hs_q;
    assign hc_ext = {1'b0, hcount_q};

    // Synchronise CGA syncs; hsync falling edge becomes the line start.
    always_ff @(posedge clk25m or posedge reset) begin
        if (reset) begin
            hs_q      <= 1'b1;
            hs_prev_q <= 1'b1;
            vs1_q     <= 1'b1;
            vs2_q     <= 1'b1;
        end else begin
            hs_q      <= lb.cga_hsync_i;
            hs_prev_q <= hs_q;
            vs1_q     <= lb.cga_vsync_i;
            vs2_q     <= vs1_q;
        end
    end

    // Write side: bank swap on line start, one write per strobe until full.
    always_ff @(posedge clk25m or posedge reset) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            wptr_q    <= '0;
            armed_q   <= 1'b0;
            rd_bank_q <= 1'b1;
        end else begin
            wr_en_q <= 1'b0;
            if (ls) begin
                rd_bank_q <= wr_bank_q;
                wr_bank_q <= ~wr_bank_q;
                armed_q   <= 1'b1;
                wptr_q    <= '0;
                if (lb.cga_pix_ce) begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= '0;
                    wptr_q    <= (ADDR_W+1)'(1);
                end
            end else if (lb.cga_pix_ce && armed_q) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= wptr_q[ADDR_W-1:0];
                wptr_q    <= wptr_q + (ADDR_W+1)'(1);
                if (wptr_q == W_LAST) begin
                    armed_q <= 1'b0;
                end
            end
        end
    end

    // Read FSM state and horizontal counter register.
    always_ff @(posedge clk25m or posedge reset) begin
        if (reset) begin
            state_q  <= PASS0;
            hcount_q <= '0;
        end else begin
            state_q  <= state_d;
            hcount_q <= hcount_d;
        end
    end

    // Read FSM next state: two passes per line, line start wins over wrap.
    always_comb begin
        state_d  = state_q;
        hcount_d = hcount_q;
        if (ls) begin
            state_d  = PASS0;
            hcount_d = '0;
        end else begin
            case (state_q)
                PASS0: begin
                    if (hcount_q == HC_LAST) begin
                        hcount_d = '0;
                        state_d  = PASS1;
                    end else begin
                        hcount_d = hcount_q + HC_W'(1);
                    end
                end
                PASS1: begin
                    if (hcount_q == HC_LAST) begin
                        state_d = WAIT;
                    end else begin
                        hcount_d = hcount_q + HC_W'(1);
                    end
                end
                WAIT:    state_d = WAIT;
                default: state_d = PASS0;
            endcase
        end
    end

    // Registered read address and VGA timing; sticky overrun on short lines.
    always_ff @(posedge clk25m or posedge reset) begin
        if (reset) begin
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            blank_q    <= 1'b1;
            hsync_q    <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            rd_addr_q  <= hcount_q[ADDR_W:1];
            rd_valid_q <= (hc_ext < RD_END) && (state_q != WAIT);
            blank_q    <= (hc_ext >= ACT_END) || (state_q == WAIT);
            hsync_q    <= !((hc_ext >= HS_S) && (hc_ext < HS_E) && (state_q != WAIT));
            if (ls && (state_q == PASS0) && (hcount_q != '0)) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef LINEBUF_SCANLINE_EN
    logic scan_dim_q;

    // Second-pass visible pixels, aligned with rd_valid.
    always_ff @(posedge clk25m or posedge reset) begin
        if (reset) begin
            scan_dim_q <= 1'b0;
        end else begin
            scan_dim_q <= (state_q == PASS1) && (hc_ext < RD_END);
        end
    end

    assign lb.scan_dim = scan_dim_q;
`else
    assign lb.scan_dim = 1'b0;
`endif

    assign lb.wr_en       = wr_en_q;
    assign lb.wr_bank     = wr_bank_q;
    assign lb.wr_addr     = wr_addr_q;
    assign lb.rd_bank     = rd_bank_q;
    assign lb.rd_addr     = rd_addr_q;
    assign lb.rd_valid    = rd_valid_q;
    assign lb.vga_hsync_o = hsync_q;
    assign lb.vga_vsync_o = vs2_q;
    assign lb.blank_o     = blank_q;
    assign lb.overrun     = overrun_q;
endmodule

// File: tb/tb_linebuf_dbl_ctl.sv
// Directed bench for linebuf_dbl_ctl: idle timing, line writes, double
// replay, bank ping-pong, overrun, ls/strobe coincidence, async reset.
module tb_linebuf_dbl_ctl;
    localparam int ADDR_W = 9;
`ifdef LINEBUF_SCANLINE_EN
    localparam int SD_PASS = 512;
`else
    localparam int SD_PASS = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #20 clk = ~clk;

    linebuf_dbl_ctl_if #(.ADDR_W(ADDR_W)) lb ();

    linebuf_dbl_ctl dut (
        .clk25m (clk),
        .reset  (rst),
        .lb     (lb)
    );

    int n_checks = 0;
    int n_errors = 0;

    int wr_pulses, rv_cnt, blank_lo, hs_lo, sd_cnt, wr_viol;
    int exp_wa;
    int exp_wb, exp_rb;
    logic cur_ce;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        wr_pulses = 0; rv_cnt = 0; blank_lo = 0; hs_lo = 0; sd_cnt = 0; wr_viol = 0;
    endtask

    task automatic step();
        cur_ce = lb.cga_pix_ce;
        @(posedge clk);
        #1;
        if (lb.wr_en) begin
            check_val("wr_addr", int'(lb.wr_addr), exp_wa);
            check_val("wr_bank", int'(lb.wr_bank), exp_wb);
            exp_wa++;
            wr_pulses++;
            if (!cur_ce) wr_viol++;
        end
        if (lb.rd_valid) begin
            check_val("rd_addr", int'(lb.rd_addr), (rv_cnt % 512) / 2);
            rv_cnt++;
        end
        if (!lb.blank_o)     blank_lo++;
        if (!lb.vga_hsync_o) hs_lo++;
        if (lb.scan_dim)     sd_cnt++;
    endtask

    task automatic check_window(input string tag, input int e_wr, input int e_rv,
                                input int e_bl, input int e_hs, input int e_sd);
        check_val({tag, "_wr_pulses"}, wr_pulses, e_wr);
        check_val({tag, "_wr_unstrobed"}, wr_viol, 0);
        check_val({tag, "_rd_valid_cnt"}, rv_cnt, e_rv);
        check_val({tag, "_visible_cnt"}, blank_lo, e_bl);
        check_val({tag, "_hsync_lo_cnt"}, hs_lo, e_hs);
        check_val({tag, "_scan_dim_cnt"}, sd_cnt, e_sd);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_wr_en"},    int'(lb.wr_en), 0);
        check_val({tag, "_wr_bank"},  int'(lb.wr_bank), 0);
        check_val({tag, "_wr_addr"},  int'(lb.wr_addr), 0);
        check_val({tag, "_rd_bank"},  int'(lb.rd_bank), 1);
        check_val({tag, "_rd_addr"},  int'(lb.rd_addr), 0);
        check_val({tag, "_rd_valid"}, int'(lb.rd_valid), 0);
        check_val({tag, "_hsync"},    int'(lb.vga_hsync_o), 1);
        check_val({tag, "_vsync"},    int'(lb.vga_vsync_o), 1);
        check_val({tag, "_blank"},    int'(lb.blank_o), 1);
        check_val({tag, "_overrun"},  int'(lb.overrun), 0);
        check_val({tag, "_scan_dim"}, int'(lb.scan_dim), 0);
    endtask

    // One CGA line of len clocks from the ls just taken; the next ls lands on
    // the final step. nstr strobes every 4 clocks, optionally one more on ls.
    task automatic run_line(input string tag, input int len, input int nstr,
                            input bit coinc_next, input int e_wr, input int e_rv,
                            input int e_bl, input int e_hs, input int e_sd,
                            input int e_ov);
        clear_stats();
        for (int k = 1; k <= len; k++) begin
            lb.cga_hsync_i = (k >= len - 1) ? 1'b0 : 1'b1;
            lb.cga_pix_ce  = (((k - 1) % 4 == 0) && ((k - 1) / 4 < nstr)) ||
                             (coinc_next && (k == len));
            if (k == len) begin
                exp_wb = 1 - exp_wb;
                exp_rb = 1 - exp_rb;
                exp_wa = 0;
            end
            step();
        end
        lb.cga_pix_ce = 1'b0;
        check_window(tag, e_wr, e_rv, e_bl, e_hs, e_sd);
        check_val({tag, "_rd_bank_next"}, int'(lb.rd_bank), exp_rb);
        check_val({tag, "_wr_bank_next"}, int'(lb.wr_bank), exp_wb);
        check_val({tag, "_overrun"}, int'(lb.overrun), e_ov);
    endtask

    initial begin
        rst = 1'b1;
        lb.cga_pix_ce  = 1'b0;
        lb.cga_hsync_i = 1'b1;
        lb.cga_vsync_i = 1'b1;
        exp_wa = 0; exp_wb = 0; exp_rb = 1;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 1'b0;

        // Free-running after reset with no line start: PASS0, PASS1, WAIT.
        for (int i = 0; i < 800; i++) step();
        check_window("idle_pass0", 0, 512, 640, 96, 0);
        clear_stats();
        for (int i = 0; i < 800; i++) step();
        check_window("idle_pass1", 0, 512, 640, 96, SD_PASS);
        clear_stats();
        for (int i = 0; i < 300; i++) step();
        check_window("idle_wait", 0, 0, 0, 0, 0);

        // Vertical sync has two clocks of latency.
        lb.cga_vsync_i = 1'b0;
        step(); check_val("vsync_fall_d1", int'(lb.vga_vsync_o), 1);
        step(); check_val("vsync_fall_d2", int'(lb.vga_vsync_o), 0);
        lb.cga_vsync_i = 1'b1;
        step(); check_val("vsync_rise_d1", int'(lb.vga_vsync_o), 0);
        step(); check_val("vsync_rise_d2", int'(lb.vga_vsync_o), 1);

        // First line start: ls acts on the second edge after the pin falls.
        lb.cga_hsync_i = 1'b0;
        step();
        check_val("ls_not_yet_rd_bank", int'(lb.rd_bank), 1);
        exp_wb = 1; exp_rb = 0;
        step();
        check_val("ls_rd_bank", int'(lb.rd_bank), exp_rb);
        check_val("ls_wr_bank", int'(lb.wr_bank), exp_wb);

        run_line("lineA", 1700, 300, 1'b1, 257, 1024, 1280, 192, SD_PASS, 0);
        check_val("coinc_wr_en",   int'(lb.wr_en), 1);
        check_val("coinc_wr_addr", int'(lb.wr_addr), 0);
        check_val("coinc_wr_bank", int'(lb.wr_bank), 0);
        run_line("lineB", 1700, 255, 1'b0, 255, 1024, 1280, 192, SD_PASS, 0);
        run_line("lineC", 500,  100, 1'b0, 100, 500,  500,  0,   0,       1);
        run_line("lineD", 1700, 256, 1'b0, 256, 1024, 1280, 192, SD_PASS, 1);
        run_line("lineE", 1700, 10,  1'b0, 10,  1024, 1280, 192, SD_PASS, 1);

        // Reset in the middle of a line returns everything at once.
        lb.cga_hsync_i = 1'b1;
        for (int i = 0; i < 100; i++) step();
        check_val("mid_rd_valid", int'(lb.rd_valid), 1);
        rst = 1'b1;
        #1;
        check_reset("midrst");
        #5;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
